// File: rtl/window_std_dev_seq.sv
// Multi-cycle N-scaled window variance and floor-sqrt std-dev for the Viola-Jones scanner.
// Valid/ready on both sides; one job in flight; restoring square root, one bit per cycle.
module window_std_dev_seq #(
    parameter int WINDOW_SIZE = 24,
    parameter int DATA_W      = 32,
    parameter int SQ_W        = 32,
    parameter int VAR_W       = 64
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   clear,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [DATA_W-1:0]      int_tl,
    input  logic [DATA_W-1:0]      int_tr,
    input  logic [DATA_W-1:0]      int_bl,
    input  logic [DATA_W-1:0]      int_br,
    input  logic [SQ_W-1:0]        sq_tl,
    input  logic [SQ_W-1:0]        sq_tr,
    input  logic [SQ_W-1:0]        sq_bl,
    input  logic [SQ_W-1:0]        sq_br,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [VAR_W-1:0]       out_variance,
    output logic [VAR_W/2-1:0]     out_std_dev
);

    localparam int ROOT_W = VAR_W / 2;
    localparam int REM_W  = ROOT_W + 1;
    localparam int CNT_W  = $clog2(ROOT_W + 1);
    localparam logic [VAR_W:0]    N_EXT     = (VAR_W+1)'(WINDOW_SIZE * WINDOW_SIZE);
    localparam logic [CNT_W-1:0]  LAST_ITER = CNT_W'(ROOT_W - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_DIFF,
        S_VAR,
        S_SQRT,
        S_DONE
    } state_t;

    state_t state, next_state;
    logic   accept;

    logic [DATA_W-1:0] c_tl, c_tr, c_bl, c_br;
    logic [SQ_W-1:0]   s_tl, s_tr, s_bl, s_br;
    logic [DATA_W-1:0] sum_q;
    logic [SQ_W-1:0]   sumsq_q;
    logic [VAR_W-1:0]  var_q;
    logic [VAR_W-1:0]  rad_q;
    logic [REM_W-1:0]  rem_q;
    logic [ROOT_W-1:0] root_q;
    logic [CNT_W-1:0]  iter_q;

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) state <= S_IDLE;
        else       state <= next_state;
    end

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        next_state = state;
        accept     = 1'b0;
        case (state)
            S_IDLE: if (in_valid) begin
                accept     = 1'b1;
                next_state = S_DIFF;
            end
            S_DIFF: next_state = S_VAR;
            S_VAR:  next_state = S_SQRT;
            S_SQRT: if (iter_q == LAST_ITER) next_state = S_DONE;
            S_DONE: if (out_ready) next_state = S_IDLE;
            default: next_state = S_IDLE;
        endcase
        // Abort wins over everything but reset, and swallows a same-cycle request.
        if (clear) begin
            next_state = S_IDLE;
            accept     = 1'b0;
        end
    end

    assign in_ready  = (state == S_IDLE);
    assign out_valid = (state == S_DONE);

    // Sign bit of the VAR_W+1 result flags corrupt corners; clamp instead of wrapping.
    logic [VAR_W:0]   var_full;
    logic [VAR_W-1:0] var_clamped;
    assign var_full    = N_EXT * (VAR_W+1)'(sumsq_q)
                       - (VAR_W+1)'(sum_q) * (VAR_W+1)'(sum_q);
    assign var_clamped = var_full[VAR_W] ? '0 : var_full[VAR_W-1:0];

    logic [REM_W+1:0]  rem_shift, trial;
    logic              rem_ge;
    logic [ROOT_W-1:0] root_next;
    assign rem_shift = {rem_q, rad_q[VAR_W-1 -: 2]};
    assign trial     = (REM_W+2)'({root_q, 2'b01});
    assign rem_ge    = (rem_shift >= trial);
    assign root_next = {root_q[ROOT_W-2:0], rem_ge};

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            {c_tl, c_tr, c_bl, c_br} <= '0;
            {s_tl, s_tr, s_bl, s_br} <= '0;
            sum_q        <= '0;
            sumsq_q      <= '0;
            var_q        <= '0;
            rad_q        <= '0;
            rem_q        <= '0;
            root_q       <= '0;
            iter_q       <= '0;
            out_variance <= '0;
            out_std_dev  <= '0;
        end else if (!clear) begin
            if (accept) begin
                {c_tl, c_tr, c_bl, c_br} <= {int_tl, int_tr, int_bl, int_br};
                {s_tl, s_tr, s_bl, s_br} <= {sq_tl, sq_tr, sq_bl, sq_br};
            end
            case (state)
                S_DIFF: begin
                    sum_q   <= c_br - c_tr - c_bl + c_tl;
                    sumsq_q <= s_br - s_tr - s_bl + s_tl;
                end
                S_VAR: begin
                    var_q  <= var_clamped;
                    rad_q  <= var_clamped;
                    rem_q  <= '0;
                    root_q <= '0;
                    iter_q <= '0;
                end
                S_SQRT: begin
                    rad_q  <= rad_q << 2;
                    rem_q  <= REM_W'(rem_ge ? rem_shift - trial : rem_shift);
                    root_q <= root_next;
                    iter_q <= iter_q + CNT_W'(1);
                    if (iter_q == LAST_ITER) begin
                        out_variance <= var_q;
                        out_std_dev  <= root_next;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
